// File: rtl/branch_resolver.sv
// Condition-evaluation and program-counter unit: registers signed compare flags,
// accepts branches over valid/ready and resolves them against the registered flags.
module branch_resolver #(
  parameter int unsigned   PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmp_valid,
  input  logic [15:0]     cmp_a,
  input  logic [15:0]     cmp_b,
  input  logic            step,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      flags,
  output logic            flags_valid,
  output logic            res_valid,
  output logic            res_taken
);

  localparam int unsigned COND_W = 3;
  localparam int unsigned FLAG_W = 4;

  localparam logic [COND_W-1:0] C_ALWAYS = 3'b000;
  localparam logic [COND_W-1:0] C_EQ     = 3'b001;
  localparam logic [COND_W-1:0] C_NEQ    = 3'b010;
  localparam logic [COND_W-1:0] C_GEQ    = 3'b011;
  localparam logic [COND_W-1:0] C_L      = 3'b100;
  localparam logic [COND_W-1:0] C_GT     = 3'b101;
  localparam logic [COND_W-1:0] C_LE     = 3'b110;
  localparam logic [COND_W-1:0] C_NEVER  = 3'b111;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_RESOLVE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     target_q, target_d;
  logic [COND_W-1:0]   cond_q, cond_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                flags_valid_q, flags_valid_d;
  logic                res_valid_q, res_valid_d;
  logic                res_taken_q, res_taken_d;
  logic                ready_q, ready_d;

  logic                eq_c, geq_c;
  logic [FLAG_W-1:0]   cmp_flags_c;
  logic                taken_c;
  logic                needs_flags_c;
  logic [PC_W-1:0]     pc_inc_c;

  // Full signed compare; flag layout is {eq, neq, geq, l}.
  always_comb begin
    eq_c        = (cmp_a == cmp_b);
    geq_c       = ($signed(cmp_a) >= $signed(cmp_b));
    cmp_flags_c = {eq_c, ~eq_c, geq_c, ~geq_c};
  end

  // Evaluate the captured condition against the flags registered this cycle.
  always_comb begin
    taken_c       = 1'b0;
    needs_flags_c = 1'b1;
    case (cond_q)
      C_ALWAYS: begin taken_c = 1'b1; needs_flags_c = 1'b0; end
      C_EQ:     taken_c = flags_q[3];
      C_NEQ:    taken_c = flags_q[2];
      C_GEQ:    taken_c = flags_q[1];
      C_L:      taken_c = flags_q[0];
      C_GT:     taken_c = flags_q[1] & flags_q[2];
      C_LE:     taken_c = flags_q[0] | flags_q[3];
      C_NEVER:  begin taken_c = 1'b0; needs_flags_c = 1'b0; end
      default:  begin taken_c = 1'b0; needs_flags_c = 1'b0; end
    endcase
  end

  assign pc_inc_c = pc_q + PC_W'(1);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    target_d      = target_q;
    cond_d        = cond_q;
    flags_d       = flags_q;
    flags_valid_d = flags_valid_q;
    res_valid_d   = 1'b0;
    res_taken_d   = res_taken_q;

    if (cmp_valid) begin
      flags_d       = cmp_flags_c;
      flags_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (br_valid) begin
          cond_d   = br_cond;
          target_d = br_target;
          state_d  = S_RESOLVE;
        end else if (step) begin
          pc_d = pc_inc_c;
        end
      end
      S_RESOLVE: begin
        // Conditional codes stall until a compare has ever produced flags.
        if (!(needs_flags_c && !flags_valid_q)) begin
          pc_d        = taken_c ? target_q : pc_inc_c;
          res_valid_d = 1'b1;
          res_taken_d = taken_c;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      target_q      <= '0;
      cond_q        <= '0;
      flags_q       <= '0;
      flags_valid_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      target_q      <= target_d;
      cond_q        <= cond_d;
      flags_q       <= flags_d;
      flags_valid_q <= flags_valid_d;
      res_valid_q   <= res_valid_d;
      res_taken_q   <= res_taken_d;
      ready_q       <= ready_d;
    end
  end

  assign br_ready    = ready_q;
  assign pc          = pc_q;
  assign flags       = flags_q;
  assign flags_valid = flags_valid_q;
  assign res_valid   = res_valid_q;
  assign res_taken   = res_taken_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: compares, branch resolution, stepping and resets.
module tb_branch_resolver;

  localparam int unsigned PC_W = 16;
  localparam logic [PC_W-1:0] RST_PC = 16'h0010;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmp_valid;
  logic [15:0]     cmp_a, cmp_b;
  logic            step;
  logic            br_valid;
  logic            br_ready;
  logic [2:0]      br_cond;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc;
  logic [3:0]      flags;
  logic            flags_valid;
  logic            res_valid;
  logic            res_taken;

  int tests = 0;
  int fails = 0;

  branch_resolver #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .cmp_valid(cmp_valid), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .step(step), .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
    .br_target(br_target), .pc(pc), .flags(flags), .flags_valid(flags_valid),
    .res_valid(res_valid), .res_taken(res_taken)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmp(input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] exp, input string tag);
    cmp_valid = 1'b1; cmp_a = a; cmp_b = b;
    tick();
    cmp_valid = 1'b0;
    chk(tag, 32'(flags), 32'(exp));
  endtask

  // Accept a branch on the next edge; leaves br_valid low afterwards.
  task automatic accept(input logic [2:0] cond, input logic [PC_W-1:0] tgt);
    br_valid = 1'b1; br_cond = cond; br_target = tgt;
    tick();
    br_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cmp_valid = 1'b0; cmp_a = '0; cmp_b = '0; step = 1'b0;
    br_valid = 1'b0; br_cond = '0; br_target = '0;
    tick(); tick();
    rst_n = 1'b1;

    // Mid-cycle asynchronous reset after moving pc away from reset value
    step = 1'b1; tick(); tick(); step = 1'b0;
    chk("pc_after_2_steps", 32'(pc), 32'h0012);
    do_cmp(16'h0001, 16'h0001, 4'b1010, "pre_reset_flags");
    #3 rst_n = 1'b0;
    #1;
    chk("rst_pc", 32'(pc), 32'(RST_PC));
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_flags_valid", 32'(flags_valid), 32'h0);
    chk("rst_br_ready", 32'(br_ready), 32'h1);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_taken", 32'(res_taken), 32'h0);
    tick();
    rst_n = 1'b1;

    // Compare flags, including signed corners
    do_cmp(16'h0005, 16'hFFFB, 4'b0110, "cmp_5_vs_m5");
    chk("flags_valid_set", 32'(flags_valid), 32'h1);
    do_cmp(16'h8000, 16'h7FFF, 4'b0101, "cmp_8000_7fff");
    do_cmp(16'h7FFF, 16'h8000, 4'b0110, "cmp_7fff_8000");
    do_cmp(16'h8000, 16'h8000, 4'b1010, "cmp_8000_8000");
    do_cmp(16'hFFFF, 16'hFFFE, 4'b0110, "cmp_ffff_fffe");

    // Taken eq branch then not-taken gt
    do_cmp(16'h0003, 16'h0003, 4'b1010, "cmp_3_3");
    chk("pc_before_br", 32'(pc), 32'h0010);
    accept(3'b001, 16'h0100);
    chk("resolve_ready_low", 32'(br_ready), 32'h0);
    chk("resolve_no_res", 32'(res_valid), 32'h0);
    chk("resolve_pc_hold", 32'(pc), 32'h0010);
    tick();
    chk("eq_res_valid", 32'(res_valid), 32'h1);
    chk("eq_taken", 32'(res_taken), 32'h1);
    chk("eq_pc", 32'(pc), 32'h0100);
    chk("eq_ready_back", 32'(br_ready), 32'h1);
    tick();
    chk("res_valid_one_cycle", 32'(res_valid), 32'h0);
    chk("res_taken_holds", 32'(res_taken), 32'h1);
    accept(3'b101, 16'h0200);
    tick();
    chk("gt_res_valid", 32'(res_valid), 32'h1);
    chk("gt_not_taken", 32'(res_taken), 32'h0);
    chk("gt_pc", 32'(pc), 32'h0101);

    // Step and wrap
    accept(3'b000, 16'hFFFE);
    tick();
    chk("always_pc", 32'(pc), 32'hFFFE);
    step = 1'b1;
    tick(); chk("step_ffff", 32'(pc), 32'hFFFF);
    tick(); chk("step_wrap", 32'(pc), 32'h0000);
    tick(); chk("step_0001", 32'(pc), 32'h0001);

    // Step ignored at accept and during RESOLVE; br_valid ignored in RESOLVE
    br_valid = 1'b1; br_cond = 3'b111; br_target = 16'h0300;
    tick();
    chk("step_ignored_accept", 32'(pc), 32'h0001);
    br_cond = 3'b000; br_target = 16'h0777;
    tick();
    br_valid = 1'b0; step = 1'b0;
    chk("never_pc", 32'(pc), 32'h0002);
    chk("never_res_valid", 32'(res_valid), 32'h1);
    chk("never_taken", 32'(res_taken), 32'h0);
    chk("no_capture_in_resolve", 32'(br_ready), 32'h1);

    // Compare during RESOLVE: evaluation uses the old flags
    do_cmp(16'h0003, 16'h0003, 4'b1010, "cmp_eq_again");
    accept(3'b001, 16'h0400);
    cmp_valid = 1'b1; cmp_a = 16'h0000; cmp_b = 16'h0001;
    tick();
    cmp_valid = 1'b0;
    chk("overlap_taken", 32'(res_taken), 32'h1);
    chk("overlap_res_valid", 32'(res_valid), 32'h1);
    chk("overlap_pc", 32'(pc), 32'h0400);
    chk("overlap_new_flags", 32'(flags), 32'h5);

    // Wait on invalid flags
    pulse_reset();
    accept(3'b011, 16'h0500);
    for (int i = 0; i < 3; i++) begin
      chk("wait_no_res", 32'(res_valid), 32'h0);
      chk("wait_ready_low", 32'(br_ready), 32'h0);
      tick();
    end
    chk("wait_pc_hold", 32'(pc), 32'(RST_PC));
    cmp_valid = 1'b1; cmp_a = 16'h0001; cmp_b = 16'h0000;
    tick();
    cmp_valid = 1'b0;
    chk("wait_cmp_edge_no_res", 32'(res_valid), 32'h0);
    chk("wait_flags_loaded", 32'(flags), 32'h6);
    tick();
    chk("wait_res_valid", 32'(res_valid), 32'h1);
    chk("wait_taken", 32'(res_taken), 32'h1);
    chk("wait_pc", 32'(pc), 32'h0500);

    // Unconditional branch with flags invalid resolves immediately
    pulse_reset();
    accept(3'b000, 16'h0600);
    tick();
    chk("always_noflags_res", 32'(res_valid), 32'h1);
    chk("always_noflags_taken", 32'(res_taken), 32'h1);
    chk("always_noflags_pc", 32'(pc), 32'h0600);

    // Reset during RESOLVE discards the branch
    accept(3'b000, 16'h0700);
    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midres_rst_res_valid", 32'(res_valid), 32'h0);
    chk("midres_rst_pc", 32'(pc), 32'(RST_PC));
    chk("midres_rst_ready", 32'(br_ready), 32'h1);
    rst_n = 1'b1;
    tick();
    chk("after_rst_res_valid", 32'(res_valid), 32'h0);
    chk("after_rst_pc", 32'(pc), 32'(RST_PC));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Condition-evaluation and program-counter unit for the zepto core: the consumer side of the 16-bit signed compare flags (eq, neq, geq, l). It computes flags from a compare request into a flag register, accepts branch requests over a valid/ready handshake, and resolves each branch against the registered flags. It then redirects or advances the PC. It sits between the decode stage, which issues compares and branches, and instruction fetch, which consumes `pc`.

## Interface
- `PC_W`, default 16: program counter width.
- `RESET_PC`, default 0: PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmp_valid`  in  1  load the flag register from `cmp_a`/`cmp_b` this edge.
- `cmp_a`, `cmp_b`  in  16 each  two's-complement operands.
- `step`  in  1  advance PC by 1 this edge (IDLE only).
- `br_valid`  in  1  branch request.
- `br_ready`  out  1  high only in IDLE.
- `br_cond`  in  3  condition code.
- `br_target`  in  PC_W  branch destination.
- `pc`  out  PC_W  current program counter (registered).
- `flags`  out  4  registered {eq, neq, geq, l}.
- `flags_valid`  out  1  set by the first compare after reset; sticky.
- `res_valid`  out  1  one-cycle pulse per resolved branch (registered).
- `res_taken`  out  1  outcome qualifying `res_valid`; holds its value until the next resolution.

## Operation
- Flag computation on `cmp_valid`, in every state:
  - eq = (a==b); neq = !eq.
  - geq = signed a >= b; l = !geq.
  - Full signed compare, correct for all 2^32 operand pairs, including opposite signs and 0x8000.
  - Exactly one of geq/l is set; exactly one of eq/neq is set.
- Condition codes:
  - 000 always; 001 eq; 010 neq; 011 geq; 100 l.
  - 101 gt (geq & neq); 110 le (l | eq); 111 never.
- States: IDLE, RESOLVE.
- IDLE:
  - `br_valid & br_ready` captures `br_cond`/`br_target` and moves to RESOLVE.
  - When no branch is accepted, `step` gives pc <= pc + 1, modulo 2^PC_W; 0xFFFF wraps to 0x0000.
  - `step` in the same cycle as branch acceptance is ignored.
- RESOLVE:
  - Conditional codes (001–110) with `flags_valid`=0: stay in RESOLVE (wait).
  - Otherwise evaluate the captured cond against the registered `flags`, i.e. the value present during this cycle.
  - A `cmp_valid` arriving in the same cycle updates the flags only after that evaluation.
  - On the resolving edge: pc <= taken ? target : pc + 1; res_valid <= 1; res_taken <= taken; state <= IDLE.
  - `step` is ignored.
- `br_valid` is ignored whenever not IDLE.
- Reset (asynchronous, any state, including mid-RESOLVE):
  - pc = RESET_PC, flags = 4'b0000, flags_valid = 0.
  - res_valid = 0, res_taken = 0, state = IDLE (br_ready = 1).
  - Any captured branch is discarded.

## Timing
- Compare latency: 1 edge. `cmp_valid` at edge k makes flags and flags_valid visible after edge k.
- Branch latency with valid flags:
  - Accept at edge k; RESOLVE during cycle k..k+1.
  - pc, res_valid and res_taken update at edge k+1.
  - br_ready is high again after edge k+1.
  - Throughput: one branch per 2 cycles.
- Compare and branch accepted at the same edge k: flags load at k and are used at resolution edge k+1.
- res_valid is high for exactly one cycle per branch and never in consecutive cycles.
- pc changes only on a `step` edge in IDLE or on the resolving edge.

## Test plan
- Reset then flags: assert rst_n=0 mid-cycle -> pc=RESET_PC immediately, flags=0000, flags_valid=0, br_ready=1. Then cmp a=0x0005, b=0xFFFB (−5) -> flags eq=0, neq=1, geq=1, l=0.
- Signed corner compares: a=0x8000,b=0x7FFF -> l=1. a=0x7FFF,b=0x8000 -> geq=1. a=b=0x8000 -> eq=1,geq=1. a=0xFFFF,b=0xFFFE -> geq=1,neq=1.
- Taken/not-taken: flags from a=3,b=3; pc=0x0010. br_cond=001 (eq), target=0x0100 -> res_valid pulse, res_taken=1, pc=0x0100. br_cond=101 (gt) -> res_taken=0, pc=0x0101.
- Wait on invalid flags: after reset, br_cond=011 (geq) -> stays in RESOLVE, br_ready=0, no res_valid. cmp a=1,b=0 arrives 3 cycles later -> resolves the next edge with taken=1. Separately, br_cond=000 with flags_valid=0 resolves without waiting, taken=1.
- Step and wrap: pc=0xFFFE, step held for 3 cycles -> 0xFFFF, 0x0000, 0x0001. step asserted in the branch-accept cycle and during RESOLVE -> no extra increment.
- Overlaps: a new cmp_valid during RESOLVE (a=0,b=1 replacing eq flags) with br_cond=001 -> evaluation uses the old eq=1, so taken=1; flags show l=1 afterward. Reset asserted during RESOLVE -> no res_valid, pc=RESET_PC.
